// File: rtl/demux_route_pkg.sv
// Shared definitions for the demux routing controller: FSM encoding and FIFO entry layout.
package demux_route_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam int ENTRY_W = 3;

    typedef struct packed {
        logic [1:0] dest;
        logic       data;
    } route_entry_t;

    function automatic route_entry_t pack_entry(input logic [1:0] dest, input logic data);
        route_entry_t e;
        e.dest = dest;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/route_sync_fifo.sv
// Synchronous FIFO with pointer-plus-count bookkeeping; full and empty decoded from the count register.
module route_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CNT_DEPTH);
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so a flushed FIFO never exposes stale requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// Routing controller for a 1x4 demux: queues requests and drives s/f/en with a settle-pulse-gap sequence.
// Optional per-channel pulse statistics are built when DEMUX_STATS_EN is defined.
module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_dest,
    input  logic       in_data,
    output logic       f,
    output logic       en,
    output logic [1:0] s,
    output logic       busy
`ifdef DEMUX_STATS_EN
    ,
    output logic [4*CNT_W-1:0] chan_cnt
`endif
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         s_q, s_d;
    logic               f_q, f_d;
    logic               en_q, en_d;
    logic               push_s, pop_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [ENTRY_W-1:0] wdata_s, rdata_s;
    route_entry_t       head_s;

    assign push_s   = in_valid && !fifo_full_s;
    assign in_ready = !fifo_full_s;
    assign wdata_s  = pack_entry(in_dest, in_data);
    assign head_s   = route_entry_t'(rdata_s);

    route_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (wdata_s),
        .pop_i   (pop_s),
        .rdata_o (rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer: s/f only load on a pop, which is only taken from IDLE or the end of GAP (en low).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        f_d     = f_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    s_d     = head_s.dest;
                    f_d     = head_s.data;
                    state_d = SETUP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = DRIVE;
                cnt_d   = HOLD_LD;
            end
            DRIVE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d   = cnt_q - CNT_ONE;
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    s_d     = head_s.dest;
                    f_d     = head_s.data;
                    state_d = SETUP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        en_d = (state_d == DRIVE);
    end

    // Sequencer and output registers; en comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            s_q     <= 2'b00;
            f_q     <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            f_q     <= f_d;
            en_q    <= en_d;
        end
    end

    assign s    = s_q;
    assign f    = f_q;
    assign en   = en_q;
    assign busy = (state_q != IDLE) || !fifo_empty_s;

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] chan_q [4];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A pulse is counted on the SETUP->DRIVE edge, i.e. the first DRIVE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                chan_q[k] <= {CNT_W{1'b0}};
            end
        end else if (state_q == SETUP) begin
            chan_q[s_q] <= sat_inc(chan_q[s_q]);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        assign chan_cnt[k*CNT_W +: CNT_W] = chan_q[k];
    end
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Bench for demux_route_ctrl: constant vector tables, a request-timeline reference model, reset and stats corners.
module tb_demux_route_ctrl;

    localparam int DEPTH1 = 4;
    localparam int HOLD1  = 4;
    localparam int GAP1   = 1;
    localparam int P1     = 1 + HOLD1 + GAP1;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_data, in_ready, f, en, busy;
    logic [1:0] in_dest, s;
    logic       rst2_n, in_valid2, in_data2, in_ready2, f2, en2, busy2;
    logic [1:0] in_dest2, s2;
`ifdef DEMUX_STATS_EN
    logic [31:0] chan_cnt;
    logic [7:0]  chan_cnt2;
`endif

    always #5 clk = ~clk;

    demux_route_ctrl #(.DEPTH(DEPTH1), .HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1)
`ifdef DEMUX_STATS_EN
        , .CNT_W(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_data(in_data), .f(f), .en(en), .s(s), .busy(busy)
`ifdef DEMUX_STATS_EN
        , .chan_cnt(chan_cnt)
`endif
    );

    demux_route_ctrl #(.DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(3)
`ifdef DEMUX_STATS_EN
        , .CNT_W(2)
`endif
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_dest(in_dest2), .in_data(in_data2), .f(f2), .en(en2), .s(s2), .busy(busy2)
`ifdef DEMUX_STATS_EN
        , .chan_cnt(chan_cnt2)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: each accepted request gets a pop time from plain timeline arithmetic.
    int cyc;
    int last_pop;
    int push_t[$];
    int pop_t[$];
    int dst[$];
    int dat[$];

    function automatic int model_count(input int e);
        int n = 0;
        foreach (push_t[i]) begin
            if (push_t[i] <= e) n++;
            if (pop_t[i] <= e) n--;
        end
        return n;
    endfunction

    // Expected {busy, in_ready, en, s[1:0], f} after edge e.
    function automatic int model_out(input int e);
        int b = 0, r, en_e = 0, s_e = 0, f_e = 0, n;
        n = model_count(e);
        r = (n < DEPTH1) ? 1 : 0;
        if (n > 0) b = 1;
        foreach (pop_t[i]) begin
            if (pop_t[i] <= e) begin
                s_e = dst[i];
                f_e = dat[i];
                if (e <= pop_t[i] + P1 - 1) b = 1;
                if (e >= pop_t[i] + 1 && e <= pop_t[i] + HOLD1) en_e = 1;
            end
        end
        return b * 32 + r * 16 + en_e * 8 + s_e * 2 + f_e;
    endfunction

    task automatic model_reset();
        cyc = 0;
        last_pop = -1000;
        push_t.delete(); pop_t.delete(); dst.delete(); dat.delete();
    endtask

    task automatic step(input logic v, input logic [1:0] d, input logic b);
        int t, p;
        in_valid = v; in_dest = d; in_data = b;
        if (v && (model_count(cyc) < DEPTH1)) begin
            t = cyc + 1;
            p = (t + 1 > last_pop + P1) ? t + 1 : last_pop + P1;
            push_t.push_back(t); pop_t.push_back(p);
            dst.push_back(int'(d)); dat.push_back(int'(b));
            last_pop = p;
        end
        @(posedge clk); cyc++;
        @(negedge clk);
        chk("model", int'({busy, in_ready, en, s, f}), model_out(cyc));
    endtask

    // s must never move while en stays high.
    int   glitches = 0;
    logic en_prev = 1'b0;
    logic [1:0] s_prev = 2'b00;
    always @(negedge clk) begin
        if (rst_n && en && en_prev && (s != s_prev)) glitches++;
        en_prev = en;
        s_prev  = s;
    end

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       b;
        logic [5:0] exp;
    } row_t;

    row_t t1[9];
    row_t t2[12];

    initial begin
        int sent;
        rst_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; in_dest = 2'd0; in_data = 1'b0;
        in_valid2 = 1'b0; in_dest2 = 2'd0; in_data2 = 1'b0;

        // {busy, in_ready, en, s, f}
        t1[0] = '{1'b1, 2'd2, 1'b1, 6'b110000};
        t1[1] = '{1'b0, 2'd0, 1'b0, 6'b110101};
        for (int i = 2; i < 6; i++) t1[i] = '{1'b0, 2'd0, 1'b0, 6'b111101};
        t1[6] = '{1'b0, 2'd0, 1'b0, 6'b110101};
        t1[7] = '{1'b0, 2'd0, 1'b0, 6'b010101};
        t1[8] = '{1'b0, 2'd0, 1'b0, 6'b010101};

        t2[0] = '{1'b1, 2'd1, 1'b0, 6'b110000};
        t2[1] = '{1'b1, 2'd3, 1'b1, 6'b110010};
        t2[2] = '{1'b0, 2'd0, 1'b0, 6'b111010};
        for (int i = 3; i < 6; i++) t2[i] = '{1'b0, 2'd0, 1'b0, 6'b110010};
        t2[6] = '{1'b0, 2'd0, 1'b0, 6'b110111};
        t2[7] = '{1'b0, 2'd0, 1'b0, 6'b111111};
        for (int i = 8; i < 11; i++) t2[i] = '{1'b0, 2'd0, 1'b0, 6'b110111};
        t2[11] = '{1'b0, 2'd0, 1'b0, 6'b010111};

        repeat (3) @(negedge clk);
        chk("reset_state", int'({busy, in_ready, en, s, f}), 32'h10);
        rst_n = 1'b1; rst2_n = 1'b1;

        // Single request timing, default parameters.
        foreach (t1[i]) begin
            in_valid = t1[i].v; in_dest = t1[i].d; in_data = t1[i].b;
            @(posedge clk); @(negedge clk);
            chk($sformatf("single_req_row%0d", i), int'({busy, in_ready, en, s, f}), int'(t1[i].exp));
        end

        // HOLD_CYCLES=1, GAP_CYCLES=3 instance.
        foreach (t2[i]) begin
            in_valid2 = t2[i].v; in_dest2 = t2[i].d; in_data2 = t2[i].b;
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold1_gap3_row%0d", i), int'({busy2, in_ready2, en2, s2, f2}), int'(t2[i].exp));
        end

        // Model-checked phases start from a clean reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1);
        repeat (30) step(1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 8; i++) step(1'b1, 2'($urandom_range(3)), 1'($urandom_range(1)));
        repeat (40) step(1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(9) < 4), 2'($urandom_range(3)), 1'($urandom_range(1)));
        repeat (40) step(1'b0, 2'd0, 1'b0);

        chk("s_stable_while_en", glitches, 0);

`ifdef DEMUX_STATS_EN
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            foreach (pop_t[i]) if (pop_t[i] + 1 <= cyc && dst[i] == k) n++;
            if (n > 255) n = 255;
            chk($sformatf("stats_ch%0d", k), int'(chan_cnt[k*8 +: 8]), n);
        end
`endif

        // Asynchronous reset in the middle of a pulse with a request still queued.
        step(1'b1, 2'd3, 1'b1);
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        chk("pre_reset_en", int'(en), 1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_en", int'({busy, in_ready, en, s, f}), 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (15) step(1'b0, 2'd0, 1'b0);

`ifdef DEMUX_STATS_EN
        // Saturating counters at CNT_W=2.
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        sent = 0;
        for (int i = 0; i < 60; i++) begin
            in_valid2 = (sent < 5) && in_ready2;
            in_dest2  = 2'd1;
            in_data2  = 1'b1;
            @(posedge clk);
            if (in_valid2) sent++;
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        repeat (20) @(negedge clk);
        chk("stats_sent", sent, 5);
        chk("stats_sat_ch0", int'(chan_cnt2[1:0]), 0);
        chk("stats_sat_ch1", int'(chan_cnt2[3:2]), 3);
        chk("stats_sat_ch2", int'(chan_cnt2[5:4]), 0);
        chk("stats_sat_ch3", int'(chan_cnt2[7:6]), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
